// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: default widths, opcode
// values understood by the 64-bit ALU, and the issue FSM state encoding.
package alu_pkg;

    localparam int DATA_W = 64;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADD    = OP_W'(0);
    localparam logic [OP_W-1:0] ALU_SUB    = OP_W'(1);
    localparam logic [OP_W-1:0] ALU_MUL    = OP_W'(2);
    localparam logic [OP_W-1:0] ALU_DIV    = OP_W'(3);
    localparam logic [OP_W-1:0] ALU_SHR    = OP_W'(4);
    localparam logic [OP_W-1:0] ALU_SHL    = OP_W'(5);
    localparam logic [OP_W-1:0] ALU_ROR    = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_ROL    = OP_W'(7);
    localparam logic [OP_W-1:0] ALU_AND    = OP_W'(8);
    localparam logic [OP_W-1:0] ALU_OR     = OP_W'(9);
    localparam logic [OP_W-1:0] ALU_NEG    = OP_W'(10);
    localparam logic [OP_W-1:0] ALU_NOT    = OP_W'(11);
    localparam logic [OP_W-1:0] ALU_OP_MAX = OP_W'(11);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the request, ALU-side and response signals of the issue stage.
//
// Handshake rule for both req_* and rsp_*: a transfer happens on the rising
// clk edge where valid and ready are both high. The producer keeps valid and
// its payload stable until that edge; ready may depend combinationally on
// state and on the other side's ready, never on the producer's valid.
//
// slave  : the issue controller (consumes requests, produces responses).
// master : its environment (request source, ALU register, result sink).
interface alu_issue_ctrl_if #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
);
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic              alu_enable;
    logic [DATA_W-1:0] alu_result;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    // Current issue FSM state, exported for observation.
    alu_pkg::state_t   state;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl, alu_enable,
               rsp_valid, rsp_data, rsp_err, state
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_result, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl, alu_enable,
               rsp_valid, rsp_data, rsp_err, state
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode classification used at request accept time:
// multicycle ops need the long settle count, illegal opcodes and divide by
// zero are kept away from the ALU entirely.
module alu_op_decode #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int OP_W   = alu_pkg::OP_W
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] b,
    output logic              is_multicycle,
    output logic              is_illegal,
    output logic              is_div0
);
    import alu_pkg::*;

    assign is_multicycle = (op == ALU_MUL) || (op == ALU_DIV);
    assign is_illegal    = (op > ALU_OP_MAX);
    assign is_div0       = (op == ALU_DIV) && (b == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of the 64-bit ALU. Latches one request onto the ALU
// inputs, waits the op-dependent settle time, pulses the ALU register
// enable once, then offers the registered result downstream. Filtered ops
// (illegal opcode, divide by zero) skip the ALU and answer with an error.
module alu_issue_ctrl #(
    parameter int DATA_W        = alu_pkg::DATA_W,
    parameter int OP_W          = alu_pkg::OP_W,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic              clk,
    input  logic              clr,
    alu_issue_ctrl_if.slave   bus
);
    import alu_pkg::*;

    localparam int              CNT_W       = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    count;
    logic                err_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [OP_W-1:0]     ctrl_q;

    logic                req_ready;
    logic                accept;
    logic                alu_enable;
    logic                is_multicycle;
    logic                is_illegal;
    logic                is_div0;
    logic                filtered;

    alu_op_decode #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_decode (
        .op            (bus.req_op),
        .b             (bus.req_b),
        .is_multicycle (is_multicycle),
        .is_illegal    (is_illegal),
        .is_div0       (is_div0)
    );

    // A new request can be taken when idle, or while the current result is
    // leaving, so back-to-back ops do not lose a cycle in IDLE.
    assign req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign accept    = bus.req_valid && req_ready;
    assign filtered  = is_illegal || is_div0;

    // Next-state and the single-cycle ALU enable pulse.
    always_comb begin
        state_nxt  = state;
        alu_enable = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = filtered ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (count == '0) begin
                    alu_enable = 1'b1;
                    state_nxt  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (accept) begin
                        state_nxt = filtered ? RESP : EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/opcode capture at accept, settle counter and error latch.
    // Filtered ops put zeros on the ALU inputs so nothing undefined is ever
    // presented to it.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            count  <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            if (filtered) begin
                a_q    <= '0;
                b_q    <= '0;
                ctrl_q <= '0;
                count  <= '0;
                err_q  <= 1'b1;
            end else begin
                a_q    <= bus.req_a;
                b_q    <= bus.req_b;
                ctrl_q <= bus.req_op;
                count  <= is_multicycle ? MULDIV_LOAD : '0;
                err_q  <= 1'b0;
            end
        end else if ((state == EXEC) && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.alu_enable = alu_enable;
    assign bus.state      = state;

    // The ALU register holds during RESP because the enable is low, so the
    // result can be passed straight through while the response is pending.
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_err    = (state == RESP) && err_q;
    assign bus.rsp_data   = ((state == RESP) && !err_q) ? bus.alu_result : '0;

endmodule
